// File: rtl/fft_pitch_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pitch_tracker
//  Description : Finds the peak bin of each magnitude-squared FFT frame
//                inside a search window, gates it against a voicing
//                threshold and publishes a pitch once it has held steady
//                for STABLE frames. The result is held in a valid/ready
//                output register; sticky flags report framing errors and
//                overwritten results.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_pitch_tracker #(
  parameter int MW       = 33,
  parameter int NSamples = 1024,
  parameter int KW       = $clog2(NSamples),
  parameter int K_MIN    = 1,
  parameter int K_MAX    = NSamples/2-1,
  parameter int STABLE   = 3,
  parameter int TOL      = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mag_valid,
  input  logic [MW-1:0] mag,
  input  logic          mag_last,
  input  logic [MW-1:0] threshold,
  output logic          pitch_valid,
  input  logic          pitch_ready,
  output logic [KW-1:0] pitch_k,
  output logic [MW-1:0] pitch_mag,
  output logic          pitch_voiced,
  output logic          frame_err,
  output logic          overrun,
  input  logic          clear_flags
);

  localparam int SCW = $clog2(STABLE + 1);

  localparam logic [KW-1:0]  c_k_last = KW'(NSamples - 1);
  localparam logic [KW-1:0]  c_k_min  = KW'(K_MIN);
  localparam logic [KW-1:0]  c_k_max  = KW'(K_MAX);
  localparam logic [KW:0]    c_tol    = (KW+1)'(TOL);
  localparam logic [SCW-1:0] c_stable = SCW'(STABLE);
  localparam logic [SCW-1:0] c_one    = SCW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EVAL = 1'b1
  } state_t;

  // Unsigned distance between two bins, one bit wider than a bin index
  function automatic logic [KW:0] abs_diff(input logic [KW-1:0] a, input logic [KW-1:0] b);
    logic [KW:0] ea;
    logic [KW:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

  // Collection state
  logic [KW-1:0]  r_k;
  logic [KW-1:0]  r_best_k;
  logic [MW-1:0]  r_best_mag;
  logic [KW-1:0]  r_frame_k;
  logic [MW-1:0]  r_frame_mag;
  logic [MW-1:0]  r_frame_thr;
  logic           r_frame_err;

  // Evaluation / publish state
  state_t         r_state;
  logic [SCW-1:0] r_stable_cnt;
  logic           r_have_prev;
  logic [KW-1:0]  r_prev_k;
  logic           r_prev_voiced;
  logic           r_published;
  logic [KW-1:0]  r_pub_k;
  logic           r_pub_voiced;
  logic           r_pitch_valid;
  logic [KW-1:0]  r_pitch_k;
  logic [MW-1:0]  r_pitch_mag;
  logic           r_pitch_voiced;
  logic           r_overrun;

  // Bin qualification and running peak including the current bin
  logic           w_candidate;
  logic           w_take;
  logic [KW-1:0]  w_cur_best_k;
  logic [MW-1:0]  w_cur_best_mag;
  logic           w_is_last;
  logic           w_frame_end;
  logic           w_frame_bad;

  assign w_candidate    = (r_k >= c_k_min) && (r_k <= c_k_max);
  assign w_take         = mag_valid && w_candidate && (mag > r_best_mag);
  assign w_cur_best_k   = w_take ? r_k : r_best_k;
  assign w_cur_best_mag = w_take ? mag : r_best_mag;
  assign w_is_last      = (r_k == c_k_last);
  assign w_frame_end    = mag_valid && mag_last && w_is_last;
  assign w_frame_bad    = mag_valid && (mag_last != w_is_last);

  // Frame evaluation terms, consumed in the EVAL cycle
  logic           w_voiced;
  logic [KW:0]    w_d_prev;
  logic [KW:0]    w_d_pub;
  logic           w_consistent;
  logic [SCW-1:0] w_stable_next;
  logic           w_publish;
  logic [KW-1:0]  w_out_k;

  assign w_voiced      = (r_frame_mag >= r_frame_thr);
  assign w_d_prev      = abs_diff(r_frame_k, r_prev_k);
  assign w_d_pub       = abs_diff(r_frame_k, r_pub_k);
  assign w_consistent  = r_have_prev && (w_voiced == r_prev_voiced) &&
                         (!w_voiced || (w_d_prev <= c_tol));
  assign w_stable_next = !w_consistent ? c_one :
                         ((r_stable_cnt >= c_stable) ? c_stable : (r_stable_cnt + 1'b1));
  // Pitch distance only matters between two voiced results; unvoiced ones all map to k=0
  assign w_publish     = (w_stable_next >= c_stable) &&
                         (!r_published || (w_voiced != r_pub_voiced) ||
                          (w_voiced && (w_d_pub > c_tol)));
  assign w_out_k       = w_voiced ? r_frame_k : '0;

  // Bin counter, running peak, end-of-frame capture and framing-error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k         <= '0;
      r_best_k    <= c_k_min;
      r_best_mag  <= '0;
      r_frame_k   <= '0;
      r_frame_mag <= '0;
      r_frame_thr <= '0;
      r_frame_err <= 1'b0;
    end else begin
      if (clear_flags) begin
        r_frame_err <= 1'b0;
      end
      if (w_frame_end) begin
        r_frame_k   <= w_cur_best_k;
        r_frame_mag <= w_cur_best_mag;
        r_frame_thr <= threshold;
        r_k         <= '0;
        r_best_k    <= c_k_min;
        r_best_mag  <= '0;
      end else if (w_frame_bad) begin
        r_k         <= '0;
        r_best_k    <= c_k_min;
        r_best_mag  <= '0;
        r_frame_err <= 1'b1;
      end else if (mag_valid) begin
        r_k         <= r_k + 1'b1;
        r_best_k    <= w_cur_best_k;
        r_best_mag  <= w_cur_best_mag;
      end
    end
  end

  // Evaluation FSM, stability tracking and the valid/ready output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_stable_cnt   <= '0;
      r_have_prev    <= 1'b0;
      r_prev_k       <= '0;
      r_prev_voiced  <= 1'b0;
      r_published    <= 1'b0;
      r_pub_k        <= '0;
      r_pub_voiced   <= 1'b0;
      r_pitch_valid  <= 1'b0;
      r_pitch_k      <= '0;
      r_pitch_mag    <= '0;
      r_pitch_voiced <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      if (clear_flags) begin
        r_overrun <= 1'b0;
      end
      if (r_pitch_valid && pitch_ready) begin
        r_pitch_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_frame_end) begin
            r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          r_state       <= w_frame_end ? S_EVAL : S_IDLE;
          r_stable_cnt  <= w_stable_next;
          r_have_prev   <= 1'b1;
          r_prev_k      <= r_frame_k;
          r_prev_voiced <= w_voiced;
          if (w_publish) begin
            r_published    <= 1'b1;
            r_pub_k        <= w_out_k;
            r_pub_voiced   <= w_voiced;
            r_pitch_valid  <= 1'b1;
            r_pitch_k      <= w_out_k;
            r_pitch_mag    <= r_frame_mag;
            r_pitch_voiced <= w_voiced;
            if (r_pitch_valid && !pitch_ready) begin
              r_overrun <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pitch_valid  = r_pitch_valid;
  assign pitch_k      = r_pitch_k;
  assign pitch_mag    = r_pitch_mag;
  assign pitch_voiced = r_pitch_voiced;
  assign frame_err    = r_frame_err;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fft_pitch_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_pitch_tracker
//  Description : Directed self-checking bench for fft_pitch_tracker
//                (16-bin frames, window 1..7, STABLE=3, TOL=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_pitch_tracker;

  localparam int MW = 33;
  localparam int NS = 16;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mag_valid = 1'b0;
  logic [MW-1:0] mag = '0;
  logic          mag_last = 1'b0;
  logic [MW-1:0] threshold = 33'd100;
  logic          pitch_ready = 1'b1;
  logic          clear_flags = 1'b0;
  logic          pitch_valid;
  logic [KW-1:0] pitch_k;
  logic [MW-1:0] pitch_mag;
  logic          pitch_voiced;
  logic          frame_err;
  logic          overrun;

  int n_cmp = 0;
  int n_err = 0;

  logic [MW-1:0] fr [NS];

  always #5 clk = ~clk;

  fft_pitch_tracker #(
    .MW(MW), .NSamples(NS), .KW(KW), .K_MIN(1), .K_MAX(7), .STABLE(3), .TOL(1)
  ) dut (
    .clk(clk), .reset(reset), .mag_valid(mag_valid), .mag(mag), .mag_last(mag_last),
    .threshold(threshold), .pitch_valid(pitch_valid), .pitch_ready(pitch_ready),
    .pitch_k(pitch_k), .pitch_mag(pitch_mag), .pitch_voiced(pitch_voiced),
    .frame_err(frame_err), .overrun(overrun), .clear_flags(clear_flags)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [MW-1:0] base, input int pk, input logic [MW-1:0] pv);
    for (int i = 0; i < NS; i++) fr[i] = base;
    fr[pk] = pv;
  endtask

  // Streams fr[] as one well-formed frame; returns in cycle N+1
  task automatic send_frame();
    for (int i = 0; i < NS; i++) begin
      mag_valid = 1'b1;
      mag       = fr[i];
      mag_last  = (i == NS-1);
      tick();
    end
    mag_valid = 1'b0;
    mag_last  = 1'b0;
    mag       = '0;
  endtask

  task automatic expect_none(input string tag);
    send_frame();
    tick();
    chk(tag, 64'(pitch_valid), 64'd0);
  endtask

  task automatic expect_pub(input string tag, input int k, input int m, input int v);
    send_frame();
    tick();
    chk({tag, "_valid"},  64'(pitch_valid),  64'd1);
    chk({tag, "_k"},      64'(pitch_k),      64'(k));
    chk({tag, "_mag"},    64'(pitch_mag),    64'(m));
    chk({tag, "_voiced"}, 64'(pitch_voiced), 64'(v));
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_valid",  64'(pitch_valid),  64'd0);
    chk("rst_k",      64'(pitch_k),      64'd0);
    chk("rst_mag",    64'(pitch_mag),    64'd0);
    chk("rst_voiced", 64'(pitch_voiced), 64'd0);
    chk("rst_ferr",   64'(frame_err),    64'd0);
    chk("rst_ovr",    64'(overrun),      64'd0);
    reset = 1'b1;
    tick();

    // Steady voiced peak at bin 5: publishes on the third frame, 2 cycles after last bin
    fill(33'd10, 5, 33'd1000);
    expect_none("t1_f1");
    expect_none("t1_f2");
    send_frame();
    chk("t1_lat_n1", 64'(pitch_valid), 64'd0);
    tick();
    chk("t1_valid",  64'(pitch_valid),  64'd1);
    chk("t1_k",      64'(pitch_k),      64'd5);
    chk("t1_mag",    64'(pitch_mag),    64'd1000);
    chk("t1_voiced", 64'(pitch_voiced), 64'd1);
    tick();
    chk("t1_drop", 64'(pitch_valid), 64'd0);
    expect_none("t1_f4");

    // Wobble within tolerance of the published bin: no republish
    fill(33'd10, 5, 33'd1000); expect_none("t3_w5");
    fill(33'd10, 6, 33'd1000); expect_none("t3_w6");
    fill(33'd10, 5, 33'd1000); expect_none("t3_w5b");

    // Drift 6 then 7: stable count already saturated, so 7 publishes at once
    fill(33'd10, 6, 33'd1000); expect_none("t3_d6");
    fill(33'd10, 7, 33'd1000); expect_pub("t3_d7", 7, 1000, 1);
    fill(33'd10, 7, 33'd1000); expect_none("t3_d7b");

    // Tie at bins 3/6 keeps lowest; bin 9 is outside the window
    fill(33'd10, 9, 33'd9000);
    fr[3] = 33'd500;
    fr[6] = 33'd500;
    expect_none("t2_f1");
    expect_none("t2_f2");
    expect_pub("t2_f3", 3, 500, 1);

    // Below threshold: unvoiced result publishes k=0
    fill(33'd10, 2, 33'd50);
    expect_none("t4_f1");
    expect_none("t4_f2");
    expect_pub("t4_f3", 0, 50, 0);

    // Early mag_last at bin 10
    for (int i = 0; i <= 10; i++) begin
      mag_valid = 1'b1;
      mag       = 33'd10;
      mag_last  = (i == 10);
      tick();
    end
    mag_valid = 1'b0;
    mag_last  = 1'b0;
    chk("t5_ferr_set", 64'(frame_err), 64'd1);
    tick();
    chk("t5_no_eval", 64'(pitch_valid), 64'd0);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("t5_ferr_clr", 64'(frame_err), 64'd0);
    fill(33'd10, 2, 33'd50);
    expect_none("t5_resync");
    chk("t5_ferr_ok", 64'(frame_err), 64'd0);

    // Missing mag_last on bin 15, with a simultaneous clear that must lose
    for (int i = 0; i < NS; i++) begin
      mag_valid   = 1'b1;
      mag         = 33'd10;
      mag_last    = 1'b0;
      clear_flags = (i == NS-1);
      tick();
    end
    mag_valid   = 1'b0;
    clear_flags = 1'b0;
    chk("t5_ferr_win", 64'(frame_err), 64'd1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("t5_ferr_clr2", 64'(frame_err), 64'd0);
    expect_none("t5_resync2");
    chk("t5_ferr_ok2", 64'(frame_err), 64'd0);

    // Consumer stalled across two publishes
    pitch_ready = 1'b0;
    fill(33'd10, 5, 33'd1000);
    expect_none("t6_a1");
    expect_none("t6_a2");
    expect_pub("t6_a3", 5, 1000, 1);
    tick();
    chk("t6_hold_v", 64'(pitch_valid), 64'd1);
    chk("t6_hold_k", 64'(pitch_k),     64'd5);
    fill(33'd10, 2, 33'd1000);
    send_frame();
    tick();
    chk("t6_b1_k",   64'(pitch_k),  64'd5);
    chk("t6_b1_ovr", 64'(overrun),  64'd0);
    expect_pub("t6_b2_none", 5, 1000, 1);
    expect_pub("t6_b3", 2, 1000, 1);
    chk("t6_ovr", 64'(overrun), 64'd1);
    pitch_ready = 1'b1;
    tick();
    chk("t6_accept", 64'(pitch_valid), 64'd0);
    chk("t6_ovr_sticky", 64'(overrun), 64'd1);

    // Reset in the middle of a frame
    fill(33'd10, 2, 33'd1000);
    for (int i = 0; i < 5; i++) begin
      mag_valid = 1'b1;
      mag       = fr[i];
      tick();
    end
    reset = 1'b0;
    #1;
    chk("t6_rst_k",      64'(pitch_k),      64'd0);
    chk("t6_rst_mag",    64'(pitch_mag),    64'd0);
    chk("t6_rst_voiced", 64'(pitch_voiced), 64'd0);
    chk("t6_rst_ovr",    64'(overrun),      64'd0);
    mag_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    expect_none("t6_r1");
    expect_none("t6_r2");
    expect_pub("t6_r3", 2, 1000, 1);
    chk("t6_r_ferr", 64'(frame_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop if the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
